// File: rtl/wb_regfile.sv
// wb_regfile: writeback select, 32-entry regfile with write-first bypassed read ports, halt latch and valid/ready register dump
module wb_regfile #(
  parameter int BUS_SIZE = 32,
  parameter int REG_ADDR_SIZE = 5,
  parameter int REG_COUNT = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wb,
  input  logic                     i_mem_to_reg,
  input  logic                     i_halt,
  input  logic [BUS_SIZE-1:0]      i_mem_result,
  input  logic [BUS_SIZE-1:0]      i_alu_result,
  input  logic [REG_ADDR_SIZE-1:0] i_addr_wr,
  input  logic [REG_ADDR_SIZE-1:0] i_rd_addr_a,
  input  logic [REG_ADDR_SIZE-1:0] i_rd_addr_b,
  output logic [BUS_SIZE-1:0]      o_rd_data_a,
  output logic [BUS_SIZE-1:0]      o_rd_data_b,
  output logic [BUS_SIZE-1:0]      o_wb_data,
  output logic                     o_wb_commit,
  output logic                     o_halted,
  input  logic                     i_dump_start,
  output logic                     o_dump_valid,
  input  logic                     i_dump_ready,
  output logic [BUS_SIZE-1:0]      o_dump_data,
  output logic [REG_ADDR_SIZE-1:0] o_dump_idx,
  output logic                     o_dump_done
);
  typedef enum logic [1:0] {RUN, HALTED, DUMP, DONE} state_t;
  localparam logic [REG_ADDR_SIZE-1:0] LAST = REG_ADDR_SIZE'(REG_COUNT - 1);
  state_t state, state_n;
  logic [BUS_SIZE-1:0] regs [REG_COUNT];
  logic [REG_ADDR_SIZE-1:0] idx;
  assign o_wb_data = i_mem_to_reg ? i_mem_result : i_alu_result;
  assign o_wb_commit = i_wb && (i_addr_wr != '0) && (state == RUN);
  assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : (o_wb_commit && i_rd_addr_a == i_addr_wr) ? o_wb_data : regs[i_rd_addr_a];
  assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : (o_wb_commit && i_rd_addr_b == i_addr_wr) ? o_wb_data : regs[i_rd_addr_b];
  assign o_halted = state != RUN;
  assign o_dump_valid = state == DUMP;
  assign o_dump_done = state == DONE;
  assign o_dump_idx = idx;
  assign o_dump_data = (idx == '0) ? '0 : regs[idx];
  always_comb begin
    state_n = state;
    case (state)
      RUN:     state_n = i_halt ? HALTED : RUN;
      HALTED:  state_n = i_dump_start ? DUMP : HALTED;
      DUMP:    state_n = (i_dump_ready && idx == LAST) ? DONE : DUMP;
      default: state_n = HALTED;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      state <= RUN;
      idx <= '0;
    end else begin
      state <= state_n;
      if (o_wb_commit) regs[i_addr_wr] <= o_wb_data;
      if (state == HALTED && i_dump_start) idx <= '0;
      else if (state == DUMP && i_dump_ready && idx != LAST) idx <= idx + 1'b1;
    end
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB latch outputs. It selects the writeback value, commits it into a 32-entry general-purpose register file, and serves two combinational read ports to decode with write-first bypass. It latches the pipeline halt and, once halted, streams the full register contents to the debug unit over a valid/ready handshake.

Parameters:
BUS_SIZE, 32, data width of registers and writeback values
REG_ADDR_SIZE, 5, register address width
REG_COUNT, 32, number of registers; must equal 2**REG_ADDR_SIZE

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, synchronous, active-high
i_wb  in  1  writeback enable from MEM/WB
i_mem_to_reg  in  1  1 = write memory result, 0 = write ALU result
i_halt  in  1  halt marker from MEM/WB
i_mem_result  in  BUS_SIZE  load data from MEM/WB
i_alu_result  in  BUS_SIZE  ALU result from MEM/WB
i_addr_wr  in  REG_ADDR_SIZE  destination register
i_rd_addr_a  in  REG_ADDR_SIZE  read port A address
i_rd_addr_b  in  REG_ADDR_SIZE  read port B address
o_rd_data_a  out  BUS_SIZE  read port A data
o_rd_data_b  out  BUS_SIZE  read port B data
o_wb_data  out  BUS_SIZE  selected writeback value, for the forwarding unit
o_wb_commit  out  1  a write commits at the next edge
o_halted  out  1  pipeline halted
i_dump_start  in  1  start register dump; pulse
o_dump_valid  out  1  dump word valid
i_dump_ready  in  1  debug unit accepts the dump word
o_dump_data  out  BUS_SIZE  dump word
o_dump_idx  out  REG_ADDR_SIZE  register index of the current dump word
o_dump_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Writeback select is combinational: o_wb_data = i_mem_to_reg ? i_mem_result : i_alu_result.
- o_wb_commit = i_wb && (i_addr_wr != 0) && state==RUN.
- Write: at posedge, if o_wb_commit, then reg[i_addr_wr] <= o_wb_data.
- Register 0 is never written and always reads 0.
- Read ports are combinational, with zero latency.
- Read bypass: if o_wb_commit && addr == i_addr_wr, the port returns o_wb_data (write-first). Otherwise it returns reg[addr]. Port A and port B bypass independently.
- Reset: at posedge with i_reset, all registers clear to 0 and state goes to RUN. Outputs after reset: o_halted=0, o_dump_valid=0, o_dump_done=0, o_dump_idx=0, o_dump_data=reg[0]=0, o_wb_commit follows its equation. Reset wins over every other event, including mid-dump; the dump is aborted with no further valid.
- FSM states: RUN, HALTED, DUMP, DONE.
- RUN -> HALTED: at posedge with i_halt=1. A write from the same MEM/WB word (i_wb=1) still commits on that edge.
- In HALTED, DUMP and DONE, all writes are blocked and o_wb_commit=0.
- o_halted=1 in HALTED, DUMP and DONE, starting the cycle after the halt edge.
- HALTED -> DUMP: at posedge with i_dump_start=1; idx <= 0.
- i_dump_start is ignored in RUN, DUMP and DONE.
- i_halt is ignored outside RUN. Once halted, only reset returns the block to RUN.
- DUMP:
  - o_dump_valid=1, o_dump_idx=idx, o_dump_data=reg[idx] (reg[0] reads 0).
  - A transfer occurs at posedge with o_dump_valid && i_dump_ready.
  - On a transfer with idx < REG_COUNT-1: idx <= idx+1.
  - On a transfer with idx == REG_COUNT-1: go to DONE; idx holds and does not wrap.
  - With ready low, valid, data and idx stay stable indefinitely.
  - Valid never drops without a transfer, except on reset.
- DONE: o_dump_done=1 for exactly one cycle and o_dump_valid=0, then return to HALTED. A later i_dump_start replays the dump from idx 0.
- o_dump_idx and o_dump_data are defined only when o_dump_valid=1. They may hold their last values otherwise.

Test Plan:
1. Reset, then i_wb=1, i_mem_to_reg=0, i_alu_result=0x0000_00AA, i_addr_wr=5 for one cycle -> o_wb_commit=1; next cycle, reading address 5 returns 0x0000_00AA.
2. i_wb=1, i_mem_to_reg=1, i_mem_result=0xDEAD_BEEF, i_addr_wr=7, with i_rd_addr_a=7 in the same cycle -> o_rd_data_a=0xDEAD_BEEF combinationally (bypass), and port B at address 7 also matches. A write to address 0 with 0xFFFF_FFFF -> o_wb_commit=0; address 0 reads 0, including via bypass.
3. i_halt=1 together with i_wb=1 to r3 with 0x33 -> r3=0x33 and o_halted=1 the next cycle. A later i_wb=1 to r3 with 0x44 -> o_wb_commit=0 and r3 stays 0x33.
4. After case 3, pulse i_dump_start with i_dump_ready=1 -> 32 consecutive valid cycles with idx 0..31 and data matching the register contents (idx 3 = 0x33). Then o_dump_done is high for one cycle and valid is 0.
5. During the dump, hold i_dump_ready=0 for 5 cycles at idx=10 -> valid, idx=10 and data remain stable. Releasing ready resumes at idx=10, with no skip or duplicate.
6. Assert i_reset at idx=20 mid-dump -> next cycle valid=0, o_halted=0, all registers read 0, and a new write to r5 commits normally.
